// File: rtl/byteswap_pkg.sv
// Shared definitions for the byteswap swapper stages: FSM encoding, byte-lane
// geometry and the final-beat keep mask.
package byteswap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DW    = 512;
    localparam int BPB   = DW / 8;
    localparam int OFF_W = $clog2(BPB);

    // A zero remainder means the final beat is completely full.
    function automatic logic [BPB-1:0] keep_mask(input logic [OFF_W-1:0] rem);
        if (rem == '0) begin
            return '1;
        end
        return (BPB'(1) << rem) - BPB'(1);
    endfunction

endpackage

// File: rtl/byteswap_framer_if.sv
// Raw input stream plus framed AXI4-Stream output of the byteswap framer.
// The master modport is the framer; the slave modport is its surroundings.
interface byteswap_framer_if
    import byteswap_pkg::*;
#(
    parameter int DATA_W = DW
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_W-1:0]     s_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_W-1:0]     m_axis_tdata;
    logic [DATA_W/8-1:0]   m_axis_tkeep;
    logic                  m_axis_tlast;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/byteswap_axis_skid.sv
// Two-entry AXI-Stream register slice: output and ready are both registered,
// so full throughput is kept without a combinational ready path.
module byteswap_axis_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         push;

    assign in_ready = ~skid_valid;
    assign push     = in_valid && in_ready;

    // NOTE: the data registers are reset too, so a discarded packet leaves no stale beat behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= push;
                if (push) begin
                    out_data <= in_data;
                end
            end
        end else if (push) begin
            // Output is stalled: park the incoming beat and drop ready next cycle.
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/byteswap_framer.sv
// Frames a raw word stream into one AXI4-Stream packet of ctrl_length bytes,
// generating tkeep/tlast and a done pulse after the last beat leaves.
module byteswap_framer
    import byteswap_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = DW,
    parameter int C_LENGTH_WIDTH     = 32
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_aresetn,
    input  logic                      ctrl_start,
    input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
    output logic                      ctrl_busy,
    output logic                      ctrl_done,
    byteswap_framer_if.master         axis
);
    localparam int KW     = C_AXIS_TDATA_WIDTH / 8;
    localparam int OW     = $clog2(KW);
    localparam int BEAT_W = C_LENGTH_WIDTH - OW + 1;
    localparam int SKID_W = C_AXIS_TDATA_WIDTH + KW + 1;

    state_t                       state, state_nx;
    logic [BEAT_W-1:0]            beats_left;
    logic [KW-1:0]                last_keep;
    logic [OW-1:0]                rem;
    logic                         skid_ready;
    logic                         push;
    logic                         final_push;
    logic [C_AXIS_TDATA_WIDTH-1:0] push_data;
    logic [KW-1:0]                push_keep;
    logic                         push_last;
    logic [SKID_W-1:0]            skid_out;

    assign rem                = ctrl_length[OW-1:0];
    assign axis.s_axis_tready = (state == ST_RUN) && skid_ready;
    assign push               = axis.s_axis_tvalid && axis.s_axis_tready;
    assign final_push         = push && (beats_left == BEAT_W'(1));
    assign ctrl_busy          = (state != ST_IDLE);
    assign ctrl_done          = (state == ST_DONE);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (ctrl_start) state_nx = (ctrl_length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (final_push) state_nx = ST_DRAIN;
            ST_DRAIN: if (axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast)
                          state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Final beat carries the partial keep and has its disabled bytes zeroed.
    always_comb begin
        push_keep = '1;
        push_last = 1'b0;
        push_data = '0;
        if (beats_left == BEAT_W'(1)) begin
            push_keep = last_keep;
            push_last = 1'b1;
        end
        for (int b = 0; b < KW; b++) begin
            push_data[b*8 +: 8] = axis.s_axis_tdata[b*8 +: 8] & {8{push_keep[b]}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            last_keep  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && ctrl_start) begin
                beats_left <= {1'b0, ctrl_length[C_LENGTH_WIDTH-1:OW]} + BEAT_W'(rem != '0);
                last_keep  <= keep_mask(rem);
            end else if (push) begin
                beats_left <= beats_left - BEAT_W'(1);
            end
        end
    end

    byteswap_axis_skid #(.W(SKID_W)) u_skid (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .in_valid  (push),
        .in_ready  (skid_ready),
        .in_data   ({push_data, push_keep, push_last}),
        .out_valid (axis.m_axis_tvalid),
        .out_ready (axis.m_axis_tready),
        .out_data  (skid_out)
    );

    assign {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast} = skid_out;

endmodule

// File: tb/tb_byteswap_framer.sv
// Randomised bench for byteswap_framer: a packet-level model predicts every
// framed beat and the done timing from the raw words accepted upstream.
module tb_byteswap_framer;
    import byteswap_pkg::*;

    localparam int LW = 32;
    localparam int CW = DW + BPB + 2;

    typedef struct {
        logic [DW-1:0]  d;
        logic [BPB-1:0] k;
        logic           l;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ctrl_start = 1'b0;
    logic [LW-1:0]   ctrl_length = '0;
    logic            ctrl_busy;
    logic            ctrl_done;

    byteswap_framer_if axis ();

    byteswap_framer #(.C_AXIS_TDATA_WIDTH(DW), .C_LENGTH_WIDTH(LW)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .ctrl_start     (ctrl_start),
        .ctrl_length    (ctrl_length),
        .ctrl_busy      (ctrl_busy),
        .ctrl_done      (ctrl_done),
        .axis           (axis)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Stimulus knobs and model inputs, written only by the main process.
    int   s_prob = 100, m_prob = 100;
    logic s_en = 1'b0;
    logic start_real = 1'b0;
    int   cur_len = 0, cur_beats = 0;

    // Model state, written only by the monitor.
    beat_t exp_q[$];
    int in_idx = 0, out_idx = 0, cyc = 0, start_cyc = 0;
    int first_out_cyc = 0, last_tail_cyc = 0, done_cnt = 0;
    int sready_cnt = 0, mvalid_cnt = 0;
    logic [DW-1:0]  tail_data;
    logic [BPB-1:0] tail_keep;
    logic           prev_stall = 1'b0;
    logic [CW-2:0]  prev_out;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Bytes carried by beat idx of a len-byte packet, expressed as a keep mask.
    function automatic logic [BPB-1:0] model_keep(input int len, input int idx);
        int nb;
        logic [BPB-1:0] k;
        nb = len - idx * BPB;
        if (nb > BPB) nb = BPB;
        k = '0;
        for (int b = 0; b < nb; b++) k[b] = 1'b1;
        return k;
    endfunction

    function automatic beat_t model_beat(input int len, input int idx, input logic [DW-1:0] w);
        beat_t bt;
        bt.k = model_keep(len, idx);
        bt.l = (idx == (len + BPB - 1) / BPB - 1);
        for (int b = 0; b < BPB; b++) bt.d[b*8 +: 8] = bt.k[b] ? w[b*8 +: 8] : 8'h00;
        return bt;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (ctrl_start && start_real) begin
                start_cyc = cyc;
                in_idx    = 0;
                out_idx   = 0;
            end
            if (axis.s_axis_tready) sready_cnt++;
            if (axis.m_axis_tvalid) mvalid_cnt++;
            if (axis.s_axis_tvalid && axis.s_axis_tready) begin
                check("input_within_len", CW'(in_idx < cur_beats), CW'(1));
                exp_q.push_back(model_beat(cur_len, in_idx, axis.s_axis_tdata));
                in_idx++;
            end
            if (prev_stall)
                check("stall_hold",
                      {axis.m_axis_tvalid, axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast},
                      {1'b1, prev_out});
            if (axis.m_axis_tvalid && axis.m_axis_tready) begin
                check("beat_expected", CW'(exp_q.size() != 0), CW'(1));
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast},
                          {e.d, e.k, e.l});
                end
                if (out_idx == 0) first_out_cyc = cyc;
                out_idx++;
                if (axis.m_axis_tlast) begin
                    last_tail_cyc = cyc;
                    tail_data     = axis.m_axis_tdata;
                    tail_keep     = axis.m_axis_tkeep;
                end
            end
            if (ctrl_done) begin
                done_cnt++;
                check("done_timing", CW'(cyc),
                      CW'((cur_len == 0) ? start_cyc + 1 : last_tail_cyc + 1));
            end
            prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
            prev_out   = {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tlast};
        end
    end

    // Raw source: holds a word until it is taken, then maybe offers the next.
    initial begin
        logic took;
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        forever begin
            @(negedge clk);
            took = axis.s_axis_tvalid && axis.s_axis_tready;
            @(posedge clk);
            #1;
            if (!s_en) begin
                axis.s_axis_tvalid = 1'b0;
            end else if (!axis.s_axis_tvalid || took) begin
                axis.s_axis_tvalid = ($urandom_range(99) < s_prob);
                axis.s_axis_tdata  = rand_word();
            end
        end
    end

    initial begin
        axis.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axis.m_axis_tready = ($urandom_range(99) < m_prob);
        end
    end

    task automatic start_pkt(input int len);
        @(posedge clk);
        #1;
        cur_len     = len;
        cur_beats   = (len + BPB - 1) / BPB;
        ctrl_length = LW'(len);
        ctrl_start  = 1'b1;
        start_real  = 1'b1;
        @(posedge clk);
        #1;
        ctrl_start  = 1'b0;
        start_real  = 1'b0;
    endtask

    task automatic run_pkt(input string name, input int len, input int sp, input int mp,
                           input bit extra_start);
        int d0, waited;
        s_prob = sp;
        m_prob = mp;
        s_en   = 1'b1;
        d0     = done_cnt;
        start_pkt(len);
        check({name, "_busy"}, CW'(ctrl_busy), CW'(1));
        if (extra_start) begin
            ctrl_length = LW'(640);
            ctrl_start  = 1'b1;
            @(posedge clk);
            #1;
            ctrl_start  = 1'b0;
        end
        waited = 0;
        while (done_cnt == d0 && waited < 3000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        s_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check({name, "_done_once"}, CW'(done_cnt - d0), CW'(1));
        check({name, "_beats_out"}, CW'(out_idx), CW'(cur_beats));
        check({name, "_beats_in"}, CW'(in_idx), CW'(cur_beats));
        check({name, "_queue_empty"}, CW'(exp_q.size()), CW'(0));
        check({name, "_idle"}, CW'(ctrl_busy), CW'(0));
    endtask

    initial begin
        int d0, sr0, mv0, waited;

        // Model pinned against hand-derived values.
        check("model_keep_100", CW'(model_keep(100, 1)), CW'(64'h0000_000F_FFFF_FFFF));
        check("model_keep_256", CW'(model_keep(256, 3)), CW'({BPB{1'b1}}));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs",
              {axis.m_axis_tvalid, axis.s_axis_tready, ctrl_busy, ctrl_done, axis.m_axis_tlast},
              CW'(0));
        check("rst_keep", CW'(axis.m_axis_tkeep), CW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_pkt("t1", 256, 100, 100, 1'b0);
        check("t1_back_to_back", CW'(last_tail_cyc - first_out_cyc), CW'(3));

        run_pkt("t2", 100, 100, 100, 1'b0);
        check("t2_tail_keep", CW'(tail_keep), CW'(64'h0000_000F_FFFF_FFFF));
        check("t2_tail_zero_bytes", CW'(tail_data >> 288), CW'(0));

        sr0 = sready_cnt;
        mv0 = mvalid_cnt;
        run_pkt("t3", 0, 100, 100, 1'b0);
        check("t3_no_tready", CW'(sready_cnt - sr0), CW'(0));
        check("t3_no_tvalid", CW'(mvalid_cnt - mv0), CW'(0));

        run_pkt("t4", 640, 50, 50, 1'b0);
        run_pkt("t4b", 1000, 50, 50, 1'b0);

        run_pkt("t5", 64, 100, 100, 1'b1);

        // Reset mid-packet after two beats have left.
        s_prob = 100;
        m_prob = 100;
        s_en   = 1'b1;
        d0     = done_cnt;
        start_pkt(256);
        waited = 0;
        while (out_idx < 2 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("t6_two_beats_before_reset", CW'(out_idx), CW'(2));
        rst_n = 1'b0;
        s_en  = 1'b0;
        #1;
        check("t6_reset_outputs", {axis.m_axis_tvalid, ctrl_busy, ctrl_done}, CW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done_for_discard", CW'(done_cnt - d0), CW'(0));
        run_pkt("t6", 128, 100, 100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
